keccak_lane_absorber: RTL and testbench

Sponge-side absorber for the Keccak datapath: accepts message lanes one 64-bit word per cycle and XORs them into the rate portion of a 1600-bit state register. It presents each full (or final) block as a packed 1600-bit state to the permutation and waits for the permuted state to return. It is the writer in front of the round logic (theta/rho/pi/chi/iota). That logic takes the packed 1600-bit state and unpacks it into 25 lanes; this block packs lanes into that format.

---
 rtl/keccak_lane_absorber.sv | 162 ++++++++++++++++
 tb/tb_keccak_lane_absorber.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_lane_absorber.sv
// keccak_lane_absorber
//
// Sponge-side absorber in front of the Keccak round logic. Message lanes
// arrive one 64-bit word per cycle. Each lane is XORed into the rate part
// of a 1600-bit state register. Each full (or final) block is then handed
// to the permutation as a packed state, and the block waits for the
// permuted state to come back.
//
// Packing: lane i = x + 5*y occupies state_out[i*64 +: 64].
//
// Optional feature macro: KECCAK_ABSORB_PAD_EN
//   defined   - pad10*1 with DSBYTE is applied in hardware on the last lane,
//               or in an extra pad block when the last lane fills the rate.
//   undefined - the caller supplies pre-padded lanes; lane_last only closes
//               the block early.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a new message (IDLE or DONE only)
//   lane_in/valid/last       message lane stream; lane_ready = accept
//   state_out/valid/ready    packed state offered to the permutation
//   perm_in/perm_valid       permuted state returned by the permutation
//   msg_done                 one-cycle pulse when the final state is loaded

module keccak_lane_absorber #(
    parameter int         RATE_LANES = 21,
    parameter logic [7:0] DSBYTE     = 8'h1F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [63:0]   lane_in,
    input  logic          lane_valid,
    input  logic          lane_last,
    output logic          lane_ready,
    output logic [1599:0] state_out,
    output logic          state_valid,
    input  logic          state_ready,
    input  logic [1599:0] perm_in,
    input  logic          perm_valid,
    output logic          msg_done
);

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        OUT,
        WAIT_PERM,
        PADBLK,
        DONE
    } state_t;

    localparam logic [4:0] LAST_K   = 5'(RATE_LANES - 1);
    localparam int         LAST_MSB = (RATE_LANES - 1) * 64 + 56;

    state_t          state;
    logic [4:0]      k;
    logic            final_blk;
    logic            pad_pending;
    logic            msg_done_q;
    logic [1599:0]   s;
    logic [1599:0]   absorb_mask;

    // Every handshake output comes from registered state, so no input
    // reaches lane_ready or state_valid combinationally.
    assign state_out   = s;
    assign lane_ready  = (state == ABSORB);
    assign state_valid = (state == OUT);
    assign msg_done    = msg_done_q;

    // XOR mask for the lane being absorbed this cycle. With padding on, the
    // domain byte and the closing 0x80 bit are folded into the same mask.
    // That way a short final block is complete on the edge it is accepted.
    // When k+1 is the last rate lane, both pad XORs land on that lane.
    always_comb begin
        absorb_mask = '0;
        absorb_mask[int'(k) * 64 +: 64] = lane_in;
`ifdef KECCAK_ABSORB_PAD_EN
        if (lane_last && (k != LAST_K)) begin
            absorb_mask[(int'(k) + 1) * 64 +: 64] ^= {56'h0, DSBYTE};
            absorb_mask[int'(LAST_K) * 64 +: 64]  ^= 64'h8000_0000_0000_0000;
        end
`endif
    end

    // Main sponge FSM. The final flag marks the block whose permutation
    // finishes the message. The pad-pending flag marks a last lane that
    // exactly filled the rate, so a separate pad-only block must follow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s           <= '0;
            k           <= '0;
            final_blk   <= 1'b0;
            pad_pending <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        s           <= '0;
                        k           <= '0;
                        final_blk   <= 1'b0;
                        pad_pending <= 1'b0;
                        state       <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (lane_valid) begin
                        s <= s ^ absorb_mask;
                        if (lane_last || (k == LAST_K)) begin
                            k     <= '0;
                            state <= OUT;
`ifdef KECCAK_ABSORB_PAD_EN
                            if (lane_last && (k == LAST_K)) begin
                                final_blk   <= 1'b0;
                                pad_pending <= 1'b1;
                            end else begin
                                final_blk <= lane_last;
                            end
`else
                            final_blk <= lane_last;
`endif
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                end
                OUT: begin
                    if (state_ready) begin
                        state <= WAIT_PERM;
                    end
                end
                WAIT_PERM: begin
                    if (perm_valid) begin
                        s <= perm_in;
                        if (pad_pending) begin
                            state <= PADBLK;
                        end else if (final_blk) begin
                            state      <= DONE;
                            msg_done_q <= 1'b1;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                PADBLK: begin
                    s[7:0]             <= s[7:0] ^ DSBYTE;
                    s[LAST_MSB +: 8]   <= s[LAST_MSB +: 8] ^ 8'h80;
                    pad_pending        <= 1'b0;
                    final_blk          <= 1'b1;
                    state              <= OUT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_lane_absorber.sv
// tb_keccak_lane_absorber
//
// Directed testbench for keccak_lane_absorber at RATE_LANES = 21 and
// DSBYTE = 8'h1F. Expected states are built by hand in exp_s from the
// lanes the bench drives. The padding scenarios are compiled only when
// KECCAK_ABSORB_PAD_EN is defined. The same macro selects the padded
// expectations elsewhere.

module tb_keccak_lane_absorber;

    localparam int RATE = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   lane_in;
    logic          lane_valid;
    logic          lane_last;
    logic          lane_ready;
    logic [1599:0] state_out;
    logic          state_valid;
    logic          state_ready;
    logic [1599:0] perm_in;
    logic          perm_valid;
    logic          msg_done;

    int            checks   = 0;
    int            failures = 0;
    logic [1599:0] exp_s;

    always #5 clk = ~clk;

    keccak_lane_absorber #(
        .RATE_LANES(RATE),
        .DSBYTE    (8'h1F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lane_in    (lane_in),
        .lane_valid (lane_valid),
        .lane_last  (lane_last),
        .lane_ready (lane_ready),
        .state_out  (state_out),
        .state_valid(state_valid),
        .state_ready(state_ready),
        .perm_in    (perm_in),
        .perm_valid (perm_valid),
        .msg_done   (msg_done)
    );

    // Advance past the next rising edge; outputs are then settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        lane_in     = '0;
        lane_valid  = 1'b0;
        lane_last   = 1'b0;
        state_ready = 1'b0;
        perm_in     = '0;
        perm_valid  = 1'b0;
    endtask

    task automatic send_lane(input logic [63:0] v, input logic last);
        lane_in    = v;
        lane_valid = 1'b1;
        lane_last  = last;
        step();
        lane_valid = 1'b0;
        lane_last  = 1'b0;
        lane_in    = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic handshake();
        state_ready = 1'b1;
        step();
        state_ready = 1'b0;
    endtask

    task automatic return_perm(input logic [1599:0] p);
        perm_in    = p;
        perm_valid = 1'b1;
        step();
        perm_valid = 1'b0;
        perm_in    = '0;
    endtask

    // Model of in-block pad10*1 for a last lane accepted at index k
    task automatic apply_pad(input int k);
`ifdef KECCAK_ABSORB_PAD_EN
        if (k < RATE - 1) begin
            exp_s[(k + 1) * 64 +: 64]  ^= 64'h1F;
            exp_s[(RATE - 1) * 64 +: 64] ^= 64'h8000_0000_0000_0000;
        end
`else
        k = k;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({lane_ready, state_valid, msg_done} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL reset_flags cycle=%0d got=%b exp=000", c,
                         {lane_ready, state_valid, msg_done});
            end
            checks++;
            if (state_out !== 1600'h0) begin
                failures++;
                $display("[TB] FAIL reset_state cycle=%0d got=%h exp=0", c, state_out);
            end
        end
    endtask

    task automatic test_full_block();
        do_start();
        checks++;
        if (lane_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_ready got=%b exp=1", lane_ready);
        end
        exp_s = '0;
        for (int i = 0; i < RATE; i++) begin
            exp_s[i * 64 +: 64] = 64'(i + 1);
            send_lane(64'(i + 1), i == RATE - 1);
        end
        checks++;
        if ({state_valid, lane_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL full_out_flags got=%b exp=10", {state_valid, lane_ready});
        end
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL full_state got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        checks++;
        if (state_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_wait_valid got=%b exp=0", state_valid);
        end
        return_perm('0);
        checks++;
        if (msg_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_done_pulse got=%b exp=1", msg_done);
        end
        step();
        checks++;
        if ({msg_done, lane_ready, state_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL full_done_state got=%b exp=000",
                     {msg_done, lane_ready, state_valid});
        end
    endtask

    task automatic test_multi_block();
        logic [1599:0] p;
        do_start();
        exp_s = '0;
        for (int i = 0; i < RATE; i++) begin
            exp_s[i * 64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i);
            send_lane(64'hA5A5_0000_0000_0000 | 64'(i), 1'b0);
        end
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL multi_block1 got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        for (int i = 0; i < 25; i++) p[i * 64 +: 64] = {32'hDEAD_BEEF, 32'(i)};
        return_perm(p);
        checks++;
        if ({msg_done, lane_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL multi_next_ready got=%b exp=01", {msg_done, lane_ready});
        end
        checks++;
        if (state_out !== p) begin
            failures++;
            $display("[TB] FAIL multi_perm_load got=%h exp=%h", state_out, p);
        end
        exp_s = p;
        exp_s[63:0]    ^= 64'hFFFF_0000_FFFF_0000;
        exp_s[127:64]  ^= 64'h1234;
        apply_pad(1);
        send_lane(64'hFFFF_0000_FFFF_0000, 1'b0);
        send_lane(64'h1234, 1'b1);
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL multi_block2 got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        return_perm({25{64'h0F0F_0F0F_0F0F_0F0F}});
        checks++;
        if (msg_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL multi_done got=%b exp=1", msg_done);
        end
    endtask

    task automatic test_start_ignored();
        do_start();
        exp_s = '0;
        exp_s[63:0]    = 64'h1;
        exp_s[127:64]  = 64'h2;
        exp_s[191:128] = 64'h3;
        apply_pad(2);
        send_lane(64'h1, 1'b0);
        send_lane(64'h2, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        send_lane(64'h3, 1'b1);
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL start_ignored got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        return_perm('0);
        step();
    endtask

    task automatic test_back_pressure();
        do_start();
        exp_s = '0;
        exp_s[63:0]   = 64'h1111;
        exp_s[127:64] = 64'h2222;
        apply_pad(1);
        send_lane(64'h1111, 1'b0);
        send_lane(64'h2222, 1'b1);
        for (int c = 0; c < 10; c++) begin
            lane_in    = '1;
            lane_valid = c[0];
            step();
            checks++;
            if ({state_valid, lane_ready} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL bp_flags cycle=%0d got=%b exp=10", c,
                         {state_valid, lane_ready});
            end
            checks++;
            if (state_out !== exp_s) begin
                failures++;
                $display("[TB] FAIL bp_state cycle=%0d got=%h exp=%h", c, state_out, exp_s);
            end
        end
        lane_valid = 1'b0;
        lane_in    = '0;
        handshake();
        return_perm('0);
        checks++;
        if (msg_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_done got=%b exp=1", msg_done);
        end
        step();
    endtask

    task automatic test_reset_wait_perm();
        do_start();
        send_lane(64'hCAFE, 1'b1);
        handshake();
        rst        = 1'b1;
        perm_in    = '1;
        perm_valid = 1'b1;
        step();
        rst        = 1'b0;
        perm_valid = 1'b0;
        perm_in    = '0;
        checks++;
        if (state_out !== 1600'h0) begin
            failures++;
            $display("[TB] FAIL rstwp_state got=%h exp=0", state_out);
        end
        checks++;
        if ({msg_done, state_valid, lane_ready} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rstwp_flags got=%b exp=000",
                     {msg_done, state_valid, lane_ready});
        end
        step();
        checks++;
        if (msg_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstwp_no_done got=%b exp=0", msg_done);
        end
    endtask

`ifdef KECCAK_ABSORB_PAD_EN
    task automatic test_pad_short();
        do_start();
        send_lane(64'h0, 1'b1);
        exp_s = '0;
        exp_s[127:64] = 64'h1F;
        exp_s[(RATE - 1) * 64 +: 64] = 64'h8000_0000_0000_0000;
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL pad_short got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        return_perm('0);
        checks++;
        if (msg_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pad_short_done got=%b exp=1", msg_done);
        end
        step();
    endtask

    task automatic test_pad_full();
        do_start();
        exp_s = '0;
        for (int i = 0; i < RATE; i++) begin
            exp_s[i * 64 +: 64] = 64'(i + 1);
            send_lane(64'(i + 1), i == RATE - 1);
        end
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL pad_full_blk1 got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        return_perm('1);
        checks++;
        if ({msg_done, lane_ready, state_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL pad_full_padblk got=%b exp=000",
                     {msg_done, lane_ready, state_valid});
        end
        step();
        exp_s = '1;
        exp_s[63:0] = ~64'h1F;
        exp_s[(RATE - 1) * 64 +: 64] = 64'h7FFF_FFFF_FFFF_FFFF;
        checks++;
        if ({state_valid, lane_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL pad_full_out got=%b exp=10", {state_valid, lane_ready});
        end
        checks++;
        if (state_out !== exp_s) begin
            failures++;
            $display("[TB] FAIL pad_full_blk2 got=%h exp=%h", state_out, exp_s);
        end
        handshake();
        return_perm('0);
        checks++;
        if (msg_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pad_full_done got=%b exp=1", msg_done);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
`ifndef KECCAK_ABSORB_PAD_EN
        test_full_block();
`endif
        test_multi_block();
        test_start_ignored();
        test_back_pressure();
        test_reset_wait_perm();
`ifdef KECCAK_ABSORB_PAD_EN
        test_pad_short();
        test_pad_full();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a run that never reaches the summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
